// File: rtl/mem_access_ctrl.sv
// MA-stage data-memory initiator: decodes loads/stores, runs one valid/ready
// request per access, formats load data and store lanes, and stalls the pipe until done.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] Write_Data_M,
  input  logic [31:0] Instr_M,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Read_Data_M,
  output logic        Stall_M,
  output logic        Misaligned_M,
  output logic        Bus_Err_M
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_valid;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [3:0]        r_wstrb;
  size_t             r_size;
  logic [1:0]        r_lane;
  logic              r_unsigned;
  logic [XLEN-1:0]   r_read_data;
  logic              r_bus_err;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_memop;
  size_t             w_size;
  logic              w_misaligned;
  logic              w_start;
  logic [XLEN-1:0]   w_wdata;
  logic [3:0]        w_wstrb;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_fmt;
  logic              w_busy;
  logic              w_busy_nxt;
  logic              w_cnt_hit;
  logic              w_capture;
  logic              w_load_done;
  logic              w_timeout;
  logic              w_unused;

  assign w_opcode   = Instr_M[6:0];
  assign w_funct3   = Instr_M[14:12];
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_memop    = w_is_load | w_is_store;
  assign w_unused   = ^{Instr_M[31:15], Instr_M[11:7]};

  // Access size; any funct3 that is not a legal byte/half encoding is a word access
  always_comb begin
    w_size = SZ_W;
    case (w_funct3)
      3'b000:  w_size = SZ_B;
      3'b001:  w_size = SZ_H;
      3'b100:  w_size = w_is_load ? SZ_B : SZ_W;
      3'b101:  w_size = w_is_load ? SZ_H : SZ_W;
      default: w_size = SZ_W;
    endcase
  end

  always_comb begin
    w_misaligned = 1'b0;
    case (w_size)
      SZ_H:    w_misaligned = ALU_Result_M[0];
      SZ_W:    w_misaligned = |ALU_Result_M[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_start = w_memop & ~w_misaligned;

  // Store lane replication and byte strobes; loads never drive strobes
  always_comb begin
    w_wdata = Write_Data_M;
    w_wstrb = 4'b1111;
    case (w_size)
      SZ_B: begin
        w_wdata = {4{Write_Data_M[7:0]}};
        w_wstrb = 4'b0001 << ALU_Result_M[1:0];
      end
      SZ_H: begin
        w_wdata = {2{Write_Data_M[15:0]}};
        w_wstrb = 4'b0011 << ALU_Result_M[1:0];
      end
      default: begin
        w_wdata = Write_Data_M;
        w_wstrb = 4'b1111;
      end
    endcase
    if (!w_is_store) begin
      w_wstrb = 4'b0000;
    end
  end

  // Load extraction from the captured lane and signedness
  assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_fmt = mem_rdata;
    case (r_size)
      SZ_B:    w_load_fmt = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    w_load_fmt = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_fmt = mem_rdata;
    endcase
  end

  assign w_busy    = (r_state == S_REQ) | (r_state == S_WAIT);
  assign w_cnt_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load_done = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = r_we ? S_DONE : S_WAIT;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_load_done = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == S_REQ) | (w_state_nxt == S_WAIT);

  // Timeout counter: cumulative over REQ and WAIT, cleared whenever outside them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((TIMEOUT != 0) && w_busy && w_busy_nxt) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Request registers, captured once in IDLE and held stable through the access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_size      <= SZ_W;
      r_lane      <= '0;
      r_unsigned  <= 1'b0;
    end else begin
      r_req_valid <= (w_state_nxt == S_REQ);
      if (w_capture) begin
        r_we       <= w_is_store;
        r_addr     <= {ALU_Result_M[31:2], 2'b00};
        r_wdata    <= w_wdata;
        r_wstrb    <= w_wstrb;
        r_size     <= w_size;
        r_lane     <= ALU_Result_M[1:0];
        r_unsigned <= w_is_load & w_funct3[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_timeout) begin
        r_read_data <= '0;
      end else if (w_load_done) begin
        r_read_data <= w_load_fmt;
      end
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_wstrb     = r_wstrb;
  assign Read_Data_M   = r_read_data;
  assign Bus_Err_M     = r_bus_err;

  // Combinational status, forced low while reset is held
  assign Stall_M      = ~rst & (((r_state == S_IDLE) & w_start) | w_busy);
  assign Misaligned_M = ~rst & w_memop & w_misaligned;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a default-timeout instance for the access paths
// and a TIMEOUT=4 instance for the bus-error path.
module tb_mem_access_ctrl;

  localparam logic [31:0] I_LB  = 32'h0000_0003;
  localparam logic [31:0] I_LH  = 32'h0000_1003;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_LBU = 32'h0000_4003;
  localparam logic [31:0] I_LHU = 32'h0000_5003;
  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu;
  logic [31:0] wdat;
  logic [31:0] instr_m;
  logic [31:0] t_instr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rdata;

  logic        req_valid, we, stall, mis, berr;
  logic [31:0] addr_o, wdata_o, rd_o;
  logic [3:0]  wstrb_o;

  logic        t_req_valid, t_we, t_stall, t_mis, t_berr;
  logic [31:0] t_addr_o, t_wdata_o, t_rd_o;
  logic [3:0]  t_wstrb_o;

  int n_cmp = 0;
  int n_err = 0;

  int          res_stall;
  bit          res_done;
  bit          res_mis;
  logic [31:0] res_addr, res_wdata, res_rd;
  logic [3:0]  res_wstrb;
  logic        res_we, res_berr;

  mem_access_ctrl u_dut (
    .clk(clk), .rst(rst), .ALU_Result_M(alu), .Write_Data_M(wdat), .Instr_M(instr_m),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_we(we), .mem_addr(addr_o),
    .mem_wdata(wdata_o), .mem_wstrb(wstrb_o), .mem_rsp_valid(rsp_valid), .mem_rdata(rdata),
    .Read_Data_M(rd_o), .Stall_M(stall), .Misaligned_M(mis), .Bus_Err_M(berr)
  );

  mem_access_ctrl #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(rst), .ALU_Result_M(alu), .Write_Data_M(wdat), .Instr_M(t_instr),
    .mem_req_valid(t_req_valid), .mem_req_ready(req_ready), .mem_we(t_we), .mem_addr(t_addr_o),
    .mem_wdata(t_wdata_o), .mem_wstrb(t_wstrb_o), .mem_rsp_valid(rsp_valid), .mem_rdata(rdata),
    .Read_Data_M(t_rd_o), .Stall_M(t_stall), .Misaligned_M(t_mis), .Bus_Err_M(t_berr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one access on the main instance; ready/rsp arrive after the given idle cycles
  task automatic run_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdv);
    int  req_i;
    int  wait_i;
    bit  hs;
    bit  started;
    req_i = 0; wait_i = 0; hs = 0; started = 0;
    res_stall = 0; res_done = 0; res_mis = 0;
    res_addr = '0; res_wdata = '0; res_rd = '0; res_wstrb = '0; res_we = 1'b0; res_berr = 1'b0;
    @(negedge clk);
    instr_m = instr; alu = a; wdat = wd; rdata = rdv;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (cyc == 0) res_mis = mis;
      if (!stall && started) begin
        res_done = 1;
        res_rd   = rd_o;
        res_berr = berr;
        break;
      end
      if (stall) begin
        started = 1;
        res_stall++;
      end
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      if (req_valid) begin
        res_addr = addr_o; res_wdata = wdata_o; res_wstrb = wstrb_o; res_we = we;
        if (req_i == rdy_dly) begin
          req_ready = 1'b1;
          hs = 1;
        end
        req_i++;
      end else if (hs && stall) begin
        if (wait_i == rsp_dly) rsp_valid = 1'b1;
        wait_i++;
      end
      @(negedge clk);
    end
    instr_m = I_NOP; req_ready = 1'b0; rsp_valid = 1'b0;
  endtask

  initial begin
    int vcnt;
    int first_v;
    int first_e;
    int ecnt;
    logic [31:0] rd_at_e;
    logic        st_at_e;

    rst = 1'b1; alu = 32'h0000_1000; wdat = '0; instr_m = I_LW; t_instr = I_NOP;
    req_ready = 1'b0; rsp_valid = 1'b0; rdata = '0;

    // Reset with an aligned load present
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valid", {31'b0, req_valid}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rdata", rd_o, 32'd0);
    check("rst_berr", {31'b0, berr}, 32'd0);
    check("rst_wstrb", {28'b0, wstrb_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    instr_m = I_NOP;
    @(negedge clk);
    rst = 1'b0;

    // LW with ready after 2 and response after 2 more idle cycles
    run_op(I_LW, 32'h0000_1000, 32'd0, 2, 2, 32'hDEAD_BEEF);
    check("lw_done", {31'b0, res_done}, 32'd1);
    check("lw_addr", res_addr, 32'h0000_1000);
    check("lw_we", {31'b0, res_we}, 32'd0);
    check("lw_rdata", res_rd, 32'hDEAD_BEEF);
    check("lw_stall", res_stall, 32'd7);
    check("lw_berr", {31'b0, res_berr}, 32'd0);

    run_op(I_LB, 32'h0000_1003, 32'd0, 0, 0, 32'h80FF_FFFF);
    check("lb_rdata", res_rd, 32'hFFFF_FF80);
    check("lb_addr", res_addr, 32'h0000_1000);
    check("lb_wstrb", {28'b0, res_wstrb}, 32'd0);
    run_op(I_LBU, 32'h0000_1003, 32'd0, 0, 0, 32'h80FF_FFFF);
    check("lbu_rdata", res_rd, 32'h0000_0080);
    run_op(I_LH, 32'h0000_1002, 32'd0, 0, 0, 32'h8001_0000);
    check("lh_rdata", res_rd, 32'hFFFF_8001);
    run_op(I_LB, 32'h0000_1000, 32'd0, 1, 0, 32'h1234_567F);
    check("lb0_rdata", res_rd, 32'h0000_007F);
    run_op(I_LHU, 32'h0000_1002, 32'd0, 0, 1, 32'h8001_0000);
    check("lhu_rdata", res_rd, 32'h0000_8001);

    // Stores: no WAIT state, lane replication, strobes, load result held
    run_op(I_SH, 32'h0000_2002, 32'h0000_1234, 0, 0, 32'd0);
    check("sh_we", {31'b0, res_we}, 32'd1);
    check("sh_wstrb", {28'b0, res_wstrb}, 32'h0000_000C);
    check("sh_wdata", res_wdata, 32'h1234_1234);
    check("sh_addr", res_addr, 32'h0000_2000);
    check("sh_stall", res_stall, 32'd2);
    check("sh_rd_hold", res_rd, 32'h0000_8001);
    run_op(I_SB, 32'h0000_2001, 32'hAABB_CCDD, 1, 0, 32'd0);
    check("sb_mis", {31'b0, res_mis}, 32'd0);
    check("sb_wstrb", {28'b0, res_wstrb}, 32'h0000_0002);
    check("sb_wdata", res_wdata, 32'hDDDD_DDDD);
    check("sb_stall", res_stall, 32'd3);
    run_op(I_SW, 32'h0000_2004, 32'h1234_5678, 0, 0, 32'd0);
    check("sw_wstrb", {28'b0, res_wstrb}, 32'h0000_000F);
    check("sw_wdata", res_wdata, 32'h1234_5678);
    check("sw_addr", res_addr, 32'h0000_2004);

    // Zero-wait load: IDLE, REQ, WAIT stalled, then DONE
    run_op(I_LW, 32'h0000_1008, 32'd0, 0, 0, 32'h1357_9BDF);
    check("lw0_stall", res_stall, 32'd3);
    check("lw0_rdata", res_rd, 32'h1357_9BDF);

    // Misaligned accesses issue nothing and do not stall
    @(negedge clk);
    instr_m = I_LW; alu = 32'h0000_1001;
    #1;
    check("mis_lw_flag", {31'b0, mis}, 32'd1);
    check("mis_lw_stall", {31'b0, stall}, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (req_valid) vcnt++;
    end
    check("mis_lw_valid", vcnt, 32'd0);
    instr_m = I_LH; alu = 32'h0000_1003;
    #1;
    check("mis_lh_flag", {31'b0, mis}, 32'd1);
    instr_m = I_SW; alu = 32'h0000_2002;
    #1;
    check("mis_sw_flag", {31'b0, mis}, 32'd1);
    instr_m = I_NOP;

    // Reset while waiting for load data abandons the access
    @(negedge clk);
    instr_m = I_LW; alu = 32'h0000_1000; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk); #1;
    req_ready = 1'b0;
    check("rw_in_wait", {30'b0, req_valid, stall}, 32'd1);
    rst = 1'b1; instr_m = I_NOP;
    @(negedge clk); #1;
    check("rw_valid", {31'b0, req_valid}, 32'd0);
    check("rw_rdata", rd_o, 32'd0);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (stall || req_valid || berr) vcnt++;
    end
    check("rw_quiet", vcnt, 32'd0);
    run_op(I_LW, 32'h0000_100C, 32'd0, 0, 0, 32'hCAFE_F00D);
    check("rw_recover", res_rd, 32'hCAFE_F00D);

    // Timeout instance: ready never arrives
    @(negedge clk);
    t_instr = I_LW; alu = 32'h0000_3000; req_ready = 1'b0;
    vcnt = 0; first_v = -1; first_e = -1; ecnt = 0; rd_at_e = 32'hFFFF_FFFF; st_at_e = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (t_req_valid) begin
        vcnt++;
        if (first_v < 0) first_v = k;
      end
      if (t_berr) begin
        ecnt++;
        if (first_e < 0) begin
          first_e = k; rd_at_e = t_rd_o; st_at_e = t_stall;
          t_instr = I_NOP;
        end
      end
      @(negedge clk);
    end
    t_instr = I_NOP;
    check("to_pulses", ecnt, 32'd1);
    check("to_delay", first_e - first_v, 32'd4);
    check("to_valid_cycles", vcnt, 32'd4);
    check("to_done_stall", {31'b0, st_at_e}, 32'd0);
    check("to_rdata", rd_at_e, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
